decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
//  Registered instruction-decode stage with a valid/ready handshake. It turns a fetched RV32 instruction into an
//  rv32i_control_word (field encodings per rv32i_types), plus illegal-instruction and M-extension flags.
//  It sits between fetch and execute, includes a 1-entry skid buffer so both sides sustain 1 instr/clk, and supports flush.
// PARAMETERS
//  XLEN      32  width of the PC carried alongside each instruction
//  ENABLE_M  1   1: decode MUL/DIV (op_reg, funct7=7'b0000001); 0: treat those encodings as illegal
//  ENABLE_CSR 1  1: decode op_csr; 0: op_csr is illegal
//  CNT_W     16  width of the saturating illegal-instruction counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous reset, active low
//  flush        in   1      synchronous flush: discard all held entries
//  in_valid     in   1      fetch presents in_instr/in_pc
//  in_ready     out  1      stage can accept this cycle (registered)
//  in_instr     in   32     raw instruction
//  in_pc        in   XLEN   instruction PC
//  out_valid    out  1      out_* holds a decoded instruction
//  out_ready    in   1      execute consumes out_* this cycle
//  out_ctrl     out  rv32i_control_word  decoded control word
//  out_instr    out  32     instruction passed through
//  out_pc       out  XLEN   PC passed through
//  out_illegal  out  1      instruction is illegal or unsupported
//  out_muldiv   out  1      M-extension op; out_muldiv_op holds its funct3
//  out_muldiv_op out 3      MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU = funct3
//  illegal_cnt  out  CNT_W  saturating count of illegal instrs handed out (out_valid&out_ready&out_illegal)
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1. State is EMPTY. Skid buffer invalid. illegal_cnt=0.
//  Decode is combinational on in_instr; the result is captured with the instruction, so latency is 1 clk from accept to out_valid.
//  Defaults: aluop=alu_add, cmp_op=beq, mem_byte_enable=4'b1111, all other fields 0, opcode=instr[6:0].
//  Per-opcode encodings (muxes, aluop, cmp_op, mdr_sel, byte enable, is_branch) follow the team's control-word table.
//  Illegal when: unknown opcode; op_reg funct7 is not in {0,0x20,(0x01 if ENABLE_M)}; funct7=0x20 with funct3 not in {add,sr};
//   op_imm shift funct7 is not in {0, 0x20 (srai only)}; load funct3 is in {3,6,7}; store funct3 > 2;
//   branch funct3 is in {2,3}; jalr funct3 != 0; op_csr with ENABLE_CSR=0.
//  Illegal result: out_ctrl all zero except opcode, out_illegal=1, out_muldiv=0.
//  M op: aluop=alu_add, regfilemux_sel=0, load_regfile=1, out_muldiv=1, out_muldiv_op=funct3.
//  Handshake: accept = in_valid & in_ready. Consume = out_valid & out_ready.
//   out_* stays stable while out_valid & !out_ready.
//  FSM states (registered):
//   EMPTY: accept -> ONE.
//   ONE:   accept & consume -> ONE (new entry loads out regs); accept & !consume -> FULL (new entry goes to skid);
//          !accept & consume -> EMPTY.
//   FULL:  in_ready=0; consume -> ONE (skid entry moves to out regs); otherwise hold.
//   in_ready = (next state != FULL), registered.
//  flush: highest priority. Next cycle state=EMPTY, out_valid=0, in_ready=1.
//   An in_valid present in the flush cycle is dropped; a consume in the flush cycle still counts.
//  illegal_cnt: +1 per consumed illegal instr; saturates at 2^CNT_W-1; flush does not clear it.
//  Async reset mid-transfer: state clears immediately; no partial entries survive.
// TESTING
//  1 Reset, then ADDI x1,x0,5 (0x00500093) with out_ready=1 -> next clk out_valid=1, aluop=alu_add, load_regfile=1,
//    regfilemux_sel=2, illegal=0.
//  2 Back-to-back stream of 8 instrs with out_ready=1 -> 8 consecutive out_valid cycles, in_ready never drops, order preserved.
//  3 out_ready=0 for 3 clks while 3 instrs offered -> 2 accepted, in_ready=0 from the 3rd cycle, out_* stable;
//    release -> both drained in order.
//  4 MUL x3,x1,x2 (0x022081B3) with ENABLE_M=1 -> out_muldiv=1, out_muldiv_op=0. With ENABLE_M=0 -> out_illegal=1,
//    out_ctrl=opcode only, illegal_cnt=1 after consume.
//  5 FULL state with flush=1 and in_valid=1 -> next clk out_valid=0, in_ready=1. The flushed and the offered instrs
//    never appear on out_*.
//  6 CNT_W=2, 5 illegal instrs (0xFFFFFFFF) consumed -> illegal_cnt sticks at 3. Assert rst_n=0 mid-stream -> all outputs 0
//    asynchronously.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// RV32 decode stage: combinational decode of the fetched instruction, captured
// into an output register with a 1-entry skid buffer behind a valid/ready
// handshake. Also produces illegal/M-extension flags and a saturating
// illegal-instruction counter.

package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // Chosen so that funct3 maps straight onto the ALU op for add/sll/xor/srl/or/and.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic {
    a1_rs1 = 1'b0,
    a1_pc  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    a2_i_imm = 3'd0,
    a2_u_imm = 3'd1,
    a2_b_imm = 3'd2,
    a2_s_imm = 3'd3,
    a2_j_imm = 3'd4,
    a2_rs2   = 3'd5
  } alumux2_sel_t;

  // rfm_ext: result supplied outside the ALU (mul/div unit, CSR file).
  typedef enum logic [3:0] {
    rfm_ext      = 4'd0,
    rfm_br_en    = 4'd1,
    rfm_alu_out  = 4'd2,
    rfm_u_imm    = 4'd3,
    rfm_pc_plus4 = 4'd4,
    rfm_mdr      = 4'd5
  } regfilemux_sel_t;

  typedef enum logic {
    mar_pc  = 1'b0,
    mar_alu = 1'b1
  } marmux_sel_t;

  typedef enum logic {
    cmp_rs2 = 1'b0,
    cmp_imm = 1'b1
  } cmpmux_sel_t;

  typedef struct packed {
    logic [6:0]      opcode;
    alu_ops          aluop;
    branch_funct3_t  cmp_op;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    cmpmux_sel_t     cmpmux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic [3:0]      mem_byte_enable;
    logic            is_branch;
    logic [2:0]      mdr_sel;
  } rv32i_control_word;

endpackage

module decode_ctrl_pipe
  import rv32i_types::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_M   = 1'b1,
  parameter bit          ENABLE_CSR = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output rv32i_control_word out_ctrl,
  output logic [31:0]       out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_illegal,
  output logic              out_muldiv,
  output logic [2:0]        out_muldiv_op,
  output logic [CNT_W-1:0]  illegal_cnt
);

  typedef struct packed {
    rv32i_control_word ctrl;
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic              illegal;
    logic              muldiv;
    logic [2:0]        muldiv_op;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  entry_t           out_q, out_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           dec;
  logic             accept, consume;
  logic [2:0]       funct3;
  logic [6:0]       funct7;

  assign funct3  = in_instr[14:12];
  assign funct7  = in_instr[31:25];
  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  // Combinational decode of the incoming instruction into a full entry.
  always_comb begin
    dec                      = '0;
    dec.instr                = in_instr;
    dec.pc                   = in_pc;
    dec.ctrl.opcode          = in_instr[6:0];
    dec.ctrl.aluop           = alu_add;
    dec.ctrl.cmp_op          = beq;
    dec.ctrl.mem_byte_enable = '1;
    case (in_instr[6:0])
      op_lui: begin
        dec.ctrl.load_regfile   = 1'b1;
        dec.ctrl.regfilemux_sel = rfm_u_imm;
      end
      op_auipc: begin
        dec.ctrl.alumux1_sel    = a1_pc;
        dec.ctrl.alumux2_sel    = a2_u_imm;
        dec.ctrl.load_regfile   = 1'b1;
        dec.ctrl.regfilemux_sel = rfm_alu_out;
      end
      op_jal: begin
        dec.ctrl.alumux1_sel    = a1_pc;
        dec.ctrl.alumux2_sel    = a2_j_imm;
        dec.ctrl.load_regfile   = 1'b1;
        dec.ctrl.regfilemux_sel = rfm_pc_plus4;
        dec.ctrl.is_branch      = 1'b1;
      end
      op_jalr: begin
        dec.ctrl.alumux2_sel    = a2_i_imm;
        dec.ctrl.load_regfile   = 1'b1;
        dec.ctrl.regfilemux_sel = rfm_pc_plus4;
        dec.ctrl.is_branch      = 1'b1;
        if (funct3 != 3'b000) dec.illegal = 1'b1;
      end
      op_br: begin
        dec.ctrl.alumux1_sel = a1_pc;
        dec.ctrl.alumux2_sel = a2_b_imm;
        dec.ctrl.cmp_op      = branch_funct3_t'(funct3);
        dec.ctrl.is_branch   = 1'b1;
        if (funct3 == 3'b010 || funct3 == 3'b011) dec.illegal = 1'b1;
      end
      op_load: begin
        dec.ctrl.alumux2_sel    = a2_i_imm;
        dec.ctrl.marmux_sel     = mar_alu;
        dec.ctrl.mem_read       = 1'b1;
        dec.ctrl.load_regfile   = 1'b1;
        dec.ctrl.regfilemux_sel = rfm_mdr;
        dec.ctrl.mdr_sel        = funct3;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec.illegal = 1'b1;
      end
      op_store: begin
        dec.ctrl.alumux2_sel = a2_s_imm;
        dec.ctrl.marmux_sel  = mar_alu;
        dec.ctrl.mem_write   = 1'b1;
        case (funct3)
          3'b000:  dec.ctrl.mem_byte_enable = 4'b0001;
          3'b001:  dec.ctrl.mem_byte_enable = 4'b0011;
          3'b010:  dec.ctrl.mem_byte_enable = 4'b1111;
          default: dec.illegal = 1'b1;
        endcase
      end
      op_imm: begin
        dec.ctrl.alumux2_sel    = a2_i_imm;
        dec.ctrl.load_regfile   = 1'b1;
        dec.ctrl.regfilemux_sel = rfm_alu_out;
        case (funct3)
          3'b010: begin
            dec.ctrl.cmp_op         = blt;
            dec.ctrl.cmpmux_sel     = cmp_imm;
            dec.ctrl.regfilemux_sel = rfm_br_en;
          end
          3'b011: begin
            dec.ctrl.cmp_op         = bltu;
            dec.ctrl.cmpmux_sel     = cmp_imm;
            dec.ctrl.regfilemux_sel = rfm_br_en;
          end
          3'b001: begin
            dec.ctrl.aluop = alu_sll;
            if (funct7 != 7'h00) dec.illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == 7'h00)      dec.ctrl.aluop = alu_srl;
            else if (funct7 == 7'h20) dec.ctrl.aluop = alu_sra;
            else                      dec.illegal    = 1'b1;
          end
          default: dec.ctrl.aluop = alu_ops'(funct3);
        endcase
      end
      op_reg: begin
        dec.ctrl.alumux2_sel    = a2_rs2;
        dec.ctrl.load_regfile   = 1'b1;
        dec.ctrl.regfilemux_sel = rfm_alu_out;
        case (funct7)
          7'h00: begin
            if (funct3 == 3'b010) begin
              dec.ctrl.cmp_op         = blt;
              dec.ctrl.regfilemux_sel = rfm_br_en;
            end else if (funct3 == 3'b011) begin
              dec.ctrl.cmp_op         = bltu;
              dec.ctrl.regfilemux_sel = rfm_br_en;
            end else begin
              dec.ctrl.aluop = alu_ops'(funct3);
            end
          end
          7'h20: begin
            if (funct3 == 3'b000)      dec.ctrl.aluop = alu_sub;
            else if (funct3 == 3'b101) dec.ctrl.aluop = alu_sra;
            else                       dec.illegal    = 1'b1;
          end
          7'h01: begin
            if (ENABLE_M) begin
              dec.ctrl.regfilemux_sel = rfm_ext;
              dec.muldiv              = 1'b1;
              dec.muldiv_op           = funct3;
            end else begin
              dec.illegal = 1'b1;
            end
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      op_csr: begin
        dec.ctrl.load_regfile   = 1'b1;
        dec.ctrl.regfilemux_sel = rfm_ext;
        if (!ENABLE_CSR) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions carry only their opcode so nothing downstream acts on them.
    if (dec.illegal) begin
      dec.ctrl        = '0;
      dec.ctrl.opcode = in_instr[6:0];
      dec.muldiv      = 1'b0;
      dec.muldiv_op   = '0;
    end
  end

  // Handshake FSM next state, output/skid register loads and illegal counter.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (consume && out_q.illegal && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    if (flush) begin
      state_d = EMPTY;
      out_d   = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_d   = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            out_d   = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_ctrl      = out_q.ctrl;
  assign out_instr     = out_q.instr;
  assign out_pc        = out_q.pc;
  assign out_illegal   = out_q.illegal;
  assign out_muldiv    = out_q.muldiv;
  assign out_muldiv_op = out_q.muldiv_op;
  assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: a full-featured instance (a) and an
// instance without M/CSR and with a 2-bit illegal counter (b) share stimulus.

module tb_decode_ctrl_pipe;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic a_in_ready, a_out_valid, a_out_illegal, a_out_muldiv;
  logic [31:0] a_out_instr, a_out_pc;
  logic [2:0] a_out_muldiv_op;
  logic [15:0] a_illegal_cnt;
  rv32i_control_word a_out_ctrl;

  logic b_in_ready, b_out_valid, b_out_illegal, b_out_muldiv;
  logic [31:0] b_out_instr, b_out_pc;
  logic [2:0] b_out_muldiv_op;
  logic [1:0] b_illegal_cnt;
  rv32i_control_word b_out_ctrl;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_CSR(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_instr(a_out_instr), .out_pc(a_out_pc),
    .out_illegal(a_out_illegal), .out_muldiv(a_out_muldiv), .out_muldiv_op(a_out_muldiv_op),
    .illegal_cnt(a_illegal_cnt)
  );

  decode_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_CSR(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_instr(b_out_instr), .out_pc(b_out_pc),
    .out_illegal(b_out_illegal), .out_muldiv(b_out_muldiv), .out_muldiv_op(b_out_muldiv_op),
    .illegal_cnt(b_illegal_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change right after a falling edge; outputs are sampled at the next one.
  task automatic cyc();
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        ill_a;
    logic        ill_b;
    logic [2:0]  aluop;
    logic [3:0]  be;
  } vec_t;

  vec_t vt [12];
  rv32i_control_word exp_ctrl;

  initial begin
    vt = '{
      '{32'h40000033, 1'b0, 1'b0, 3'd3, 4'hF},  // SUB
      '{32'h40001033, 1'b1, 1'b1, 3'd0, 4'h0},  // funct7=0x20 with sll
      '{32'h40005013, 1'b0, 1'b0, 3'd2, 4'hF},  // SRAI
      '{32'h40001013, 1'b1, 1'b1, 3'd0, 4'h0},  // SLLI with funct7=0x20
      '{32'h00003003, 1'b1, 1'b1, 3'd0, 4'h0},  // load funct3=3
      '{32'h00003023, 1'b1, 1'b1, 3'd0, 4'h0},  // store funct3=3
      '{32'h00002023, 1'b0, 1'b0, 3'd0, 4'hF},  // SW
      '{32'h00000023, 1'b0, 1'b0, 3'd0, 4'h1},  // SB
      '{32'h00002063, 1'b1, 1'b1, 3'd0, 4'h0},  // branch funct3=2
      '{32'h00001067, 1'b1, 1'b1, 3'd0, 4'h0},  // jalr funct3=1
      '{32'h00000073, 1'b0, 1'b1, 3'd0, 4'hF},  // csr opcode
      '{32'h0000007F, 1'b1, 1'b1, 3'd0, 4'h0}   // unknown opcode
    };

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    cyc();
    check_eq("rst_in_ready", 64'(a_in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_out_ctrl", 64'(a_out_ctrl), 64'd0);
    check_eq("rst_cnt", 64'(a_illegal_cnt), 64'd0);
    rst_n = 1'b1;
    cyc();

    // 1: ADDI x1,x0,5
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
    cyc();
    check_eq("t1_valid", 64'(a_out_valid), 64'd1);
    check_eq("t1_aluop", 64'(a_out_ctrl.aluop), 64'(alu_add));
    check_eq("t1_load_rf", 64'(a_out_ctrl.load_regfile), 64'd1);
    check_eq("t1_rfmux", 64'(a_out_ctrl.regfilemux_sel), 64'd2);
    check_eq("t1_illegal", 64'(a_out_illegal), 64'd0);
    check_eq("t1_pc", 64'(a_out_pc), 64'h100);
    check_eq("t1_in_ready", 64'(a_in_ready), 64'd1);
    in_valid = 1'b0;
    cyc();
    check_eq("t1_drained", 64'(a_out_valid), 64'd0);

    // 2: back-to-back stream of 8
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h00000093 | (32'(i) << 20);
      in_pc    = 32'h200 + 32'(4 * i);
      cyc();
      check_eq("t2_valid", 64'(a_out_valid), 64'd1);
      check_eq("t2_instr", 64'(a_out_instr), 64'(32'h00000093 | (32'(i) << 20)));
      check_eq("t2_in_ready", 64'(a_in_ready), 64'd1);
    end
    in_valid = 1'b0;
    cyc();
    check_eq("t2_drained", 64'(a_out_valid), 64'd0);

    // 3: stalled consumer fills the skid buffer
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
    cyc();
    check_eq("t3_c1_valid", 64'(a_out_valid), 64'd1);
    check_eq("t3_c1_rdy", 64'(a_in_ready), 64'd1);
    in_instr = 32'h00200113; in_pc = 32'h304;
    cyc();
    check_eq("t3_c2_rdy", 64'(a_in_ready), 64'd0);
    check_eq("t3_c2_instr", 64'(a_out_instr), 64'h00100093);
    in_instr = 32'h00300193; in_pc = 32'h308;
    cyc();
    check_eq("t3_c3_rdy", 64'(a_in_ready), 64'd0);
    check_eq("t3_c3_instr", 64'(a_out_instr), 64'h00100093);
    check_eq("t3_c3_pc", 64'(a_out_pc), 64'h300);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    check_eq("t3_d1_instr", 64'(a_out_instr), 64'h00200113);
    check_eq("t3_d1_valid", 64'(a_out_valid), 64'd1);
    check_eq("t3_d1_rdy", 64'(a_in_ready), 64'd1);
    cyc();
    check_eq("t3_d2_valid", 64'(a_out_valid), 64'd0);

    // 4: MUL x3,x1,x2
    in_valid = 1'b1; in_instr = 32'h022081B3; in_pc = 32'h400;
    cyc();
    check_eq("t4_a_muldiv", 64'(a_out_muldiv), 64'd1);
    check_eq("t4_a_mdop", 64'(a_out_muldiv_op), 64'd0);
    check_eq("t4_a_illegal", 64'(a_out_illegal), 64'd0);
    check_eq("t4_a_rfmux", 64'(a_out_ctrl.regfilemux_sel), 64'd0);
    check_eq("t4_a_load_rf", 64'(a_out_ctrl.load_regfile), 64'd1);
    check_eq("t4_b_illegal", 64'(b_out_illegal), 64'd1);
    check_eq("t4_b_muldiv", 64'(b_out_muldiv), 64'd0);
    exp_ctrl = '0;
    exp_ctrl.opcode = 7'h33;
    check_eq("t4_b_ctrl", 64'(b_out_ctrl), 64'(exp_ctrl));
    in_valid = 1'b0;
    cyc();
    check_eq("t4_b_cnt", 64'(b_illegal_cnt), 64'd1);
    check_eq("t4_a_cnt", 64'(a_illegal_cnt), 64'd0);

    // Illegal-rule boundaries and field encodings
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_instr = vt[i].instr; in_pc = 32'h500 + 32'(4 * i);
      cyc();
      check_eq($sformatf("v%0d_a_ill", i), 64'(a_out_illegal), 64'(vt[i].ill_a));
      check_eq($sformatf("v%0d_b_ill", i), 64'(b_out_illegal), 64'(vt[i].ill_b));
      check_eq($sformatf("v%0d_aluop", i), 64'(a_out_ctrl.aluop), 64'(vt[i].aluop));
      check_eq($sformatf("v%0d_be", i), 64'(a_out_ctrl.mem_byte_enable), 64'(vt[i].be));
    end
    in_valid = 1'b0;
    cyc();
    check_eq("vec_a_cnt", 64'(a_illegal_cnt), 64'd7);
    check_eq("vec_b_cnt_sat", 64'(b_illegal_cnt), 64'd3);

    // 5: flush while FULL with a new instruction offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00200093; in_pc = 32'h600;
    cyc();
    in_instr = 32'h00300093; in_pc = 32'h604;
    cyc();
    check_eq("t5_full_rdy", 64'(a_in_ready), 64'd0);
    flush = 1'b1; in_instr = 32'h00400093; in_pc = 32'h608;
    cyc();
    check_eq("t5_valid", 64'(a_out_valid), 64'd0);
    check_eq("t5_rdy", 64'(a_in_ready), 64'd1);
    check_eq("t5_instr", 64'(a_out_instr), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    check_eq("t5_after1", 64'(a_out_valid), 64'd0);
    cyc();
    check_eq("t5_after2", 64'(a_out_valid), 64'd0);
    check_eq("t5_cnt_kept", 64'(a_illegal_cnt), 64'd7);

    // Consume in the flush cycle still counts
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
    cyc();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    check_eq("t5_flush_cnt", 64'(a_illegal_cnt), 64'd8);
    check_eq("t5_flush_valid", 64'(a_out_valid), 64'd0);

    // 6: saturating counter after reset, then async reset mid-stream
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check_eq("t6_cnt_clr", 64'(a_illegal_cnt), 64'd0);
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("t6_illegal", 64'(a_out_illegal), 64'd1);
      check_eq("t6_b_cnt", 64'(b_illegal_cnt), 64'((i > 3) ? 3 : i));
    end
    in_valid = 1'b0;
    cyc();
    check_eq("t6_a_cnt", 64'(a_illegal_cnt), 64'd5);
    check_eq("t6_b_cnt_sat", 64'(b_illegal_cnt), 64'd3);

    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
    cyc();
    in_instr = 32'h00500093;
    cyc();
    check_eq("t6_pre_full", 64'(a_in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_ar_valid", 64'(a_out_valid), 64'd0);
    check_eq("t6_ar_rdy", 64'(a_in_ready), 64'd1);
    check_eq("t6_ar_instr", 64'(a_out_instr), 64'd0);
    check_eq("t6_ar_illegal", 64'(a_out_illegal), 64'd0);
    check_eq("t6_ar_ctrl", 64'(a_out_ctrl), 64'd0);
    check_eq("t6_ar_cnt", 64'(a_illegal_cnt), 64'd0);
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    check_eq("t6_post_valid", 64'(a_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
